// File: rtl/i2s_codec_tx_if.sv
// Stereo sample stream into the I2S transmitter: one left/right pair per valid/ready transfer.
interface i2s_codec_tx_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] lft_in;
    logic [DATA_W-1:0] rht_in;
    logic              in_vld;
    logic              in_rdy;

    modport master (output lft_in, output rht_in, output in_vld, input in_rdy);
    modport slave  (input lft_in, input rht_in, input in_vld, output in_rdy);
endinterface

// File: rtl/i2s_codec_tx.sv
// CS4272 transmit link: derives MCLK/SCLK/LRCLK from clk and serializes one stereo pair per frame in I2S format.
// Build option UNDERRUN_MUTE_EN: underrun frames send silence instead of repeating the previous pair.
module i2s_codec_tx #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SCLK_DIV  = 16,
    parameter int unsigned BIT_SLOTS = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr_undr,
    i2s_codec_tx_if.slave in_if,
    output logic          MCLK,
    output logic          SCLK,
    output logic          LRCLK,
    output logic          SDin,
    output logic          frm_strt,
    output logic          underrun
);
    localparam int unsigned CNT_W  = $clog2(2 * BIT_SLOTS * SCLK_DIV);
    localparam int unsigned SCLK_B = $clog2(SCLK_DIV) - 1;
    localparam int unsigned SLOT_W = $clog2(BIT_SLOTS);
    localparam int unsigned PAD_W  = BIT_SLOTS - 1 - DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                load_c;
    logic                run_c;
    logic                accept_c;
    logic [SLOT_W-1:0]   slot_c;
    logic [DATA_W-1:0]   word_c;
    logic [BIT_SLOTS-1:0] slots_c;
    logic                sd_c;

    logic [DATA_W-1:0]   hold_lft;
    logic [DATA_W-1:0]   hold_rht;
    logic                hold_empty;
    logic [DATA_W-1:0]   frm_lft;
    logic [DATA_W-1:0]   frm_rht;

    // State and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Leaving RUN is only allowed at the last count of a frame, so a frame is never cut short by en
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_c    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    load_c    = 1'b1;
                end
            end
            RUN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_MAX) begin
                    if (en) begin
                        load_c = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial bit for the upcoming count: slot 0 is the I2S delay bit, then MSB..LSB, then zero padding
    always_comb begin
        run_c   = (state_nxt == RUN);
        slot_c  = cnt_nxt[SCLK_B+1 +: SLOT_W];
        word_c  = cnt_nxt[CNT_W-1] ? frm_rht : frm_lft;
        slots_c = BIT_SLOTS'({1'b0, word_c}) << PAD_W;
        sd_c    = run_c & slots_c[~slot_c];
    end

    // Pin drivers track the next count so they line up with cnt; all held low in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            MCLK     <= 1'b0;
            SCLK     <= 1'b0;
            LRCLK    <= 1'b0;
            SDin     <= 1'b0;
            frm_strt <= 1'b0;
        end else begin
            MCLK     <= run_c & cnt_nxt[1];
            SCLK     <= run_c & cnt_nxt[SCLK_B];
            LRCLK    <= run_c & cnt_nxt[CNT_W-1];
            SDin     <= sd_c;
            frm_strt <= load_c;
        end
    end

    assign accept_c     = in_if.in_vld & hold_empty;
    assign in_if.in_rdy = hold_empty;

    // Holding register feeds the frame register only at frame load; a pair accepted on a load cycle waits a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_lft   <= '0;
            hold_rht   <= '0;
            hold_empty <= 1'b1;
            frm_lft    <= '0;
            frm_rht    <= '0;
            underrun   <= 1'b0;
        end else begin
            if (accept_c) begin
                hold_lft <= in_if.lft_in;
                hold_rht <= in_if.rht_in;
            end

            if (accept_c) begin
                hold_empty <= 1'b0;
            end else if (load_c) begin
                hold_empty <= 1'b1;
            end

            if (load_c && !hold_empty) begin
                frm_lft <= hold_lft;
                frm_rht <= hold_rht;
            end
`ifdef UNDERRUN_MUTE_EN
            else if (load_c) begin
                frm_lft <= '0;
                frm_rht <= '0;
            end
`endif

            if (load_c && hold_empty) begin
                underrun <= 1'b1;
            end else if (clr_undr) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_codec_tx.sv
// Bench for i2s_codec_tx: frame-level reference model, I2S receiver decoding SDin, and directed scenarios.
module tb_i2s_codec_tx;
    localparam int unsigned DATA_W = 16;
    localparam int FRAME = 1024;
    localparam int HALF  = 512;
    localparam int SLOT  = 16;
`ifdef UNDERRUN_MUTE_EN
    localparam logic [31:0] UNDR_PAIR = 32'h0000_0000;
`else
    localparam logic [31:0] UNDR_PAIR = 32'h1234_5678;
`endif

    logic clk, rst, en, clr_undr;
    logic MCLK, SCLK, LRCLK, SDin, frm_strt, underrun;
    int total = 0;
    int bad   = 0;

    i2s_codec_tx_if #(.DATA_W(DATA_W)) bus ();

    i2s_codec_tx #(.DATA_W(DATA_W), .SCLK_DIV(16), .BIT_SLOTS(32)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_undr(clr_undr), .in_if(bus),
        .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin),
        .frm_strt(frm_strt), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: frame position in clk cycles, pending-pair queue, current frame pair
    bit          m_started = 0;
    bit          m_run = 0;
    int          m_ph = 0;
    logic [15:0] m_l = '0, m_r = '0;
    bit          m_fs = 0, m_undr = 0;
    logic [31:0] pend[$];
    logic [31:0] m_sent[$];

    always @(posedge clk) begin : model
        bit load, acc;
        load = 0;
        acc  = bus.in_vld && (pend.size() == 0);
        if (rst) begin
            m_run = 0; m_ph = 0; m_l = '0; m_r = '0; m_fs = 0; m_undr = 0;
            pend.delete();
        end else begin
            if (!m_run) begin
                if (en) begin m_run = 1; m_ph = 0; load = 1; end
            end else if (m_ph == FRAME - 1) begin
                m_ph = 0;
                if (en) load = 1; else m_run = 0;
            end else begin
                m_ph++;
            end
            m_fs = load;
            if (load && pend.size() == 0) begin
                m_undr = 1;
`ifdef UNDERRUN_MUTE_EN
                m_l = '0; m_r = '0;
`endif
            end else begin
                if (load) {m_l, m_r} = pend.pop_front();
                if (clr_undr) m_undr = 0;
            end
            if (load) m_sent.push_back({m_l, m_r});
            if (acc) pend.push_back({bus.lft_in, bus.rht_in});
        end
        m_started = 1;
    end

    // Per-cycle pin check against the model
    always @(negedge clk) begin : compare
        logic [6:0] exp_v, act_v;
        logic [15:0] w;
        int slot;
        bit sd;
        if (m_started) begin
            w    = (m_ph < HALF) ? m_l : m_r;
            slot = (m_ph % HALF) / SLOT;
            sd   = m_run && slot >= 1 && slot <= 16 && w[16 - slot];
            exp_v = {m_run && ((m_ph / 2) % 2 == 1), m_run && ((m_ph / 8) % 2 == 1),
                     m_run && (m_ph >= HALF), sd, m_fs, m_undr, pend.size() == 0};
            act_v = {MCLK, SCLK, LRCLK, SDin, frm_strt, underrun, bus.in_rdy};
            chk("pins", 32'(act_v), 32'(exp_v));
        end
    end

    // I2S receiver: sample on SCLK rise, delay bit after each LRCLK change, 16 bits MSB first
    logic [31:0] rx[$];
    logic [15:0] rx_w, rx_l;
    bit rx_psclk, rx_lr;
    int rx_bit;
    always @(negedge clk) begin : receiver
        if (rst) begin
            rx_psclk = 0; rx_lr = 1; rx_bit = 0; rx_w = '0;
        end else begin
            if (SCLK && !rx_psclk) begin
                if (LRCLK != rx_lr) begin rx_bit = 0; rx_lr = LRCLK; end
                else rx_bit++;
                if (rx_bit >= 1 && rx_bit <= 16) rx_w = {rx_w[14:0], SDin};
                if (rx_bit == 16) begin
                    if (!LRCLK) rx_l = rx_w;
                    else rx.push_back({rx_l, rx_w});
                end
            end
            rx_psclk = SCLK;
        end
    end

    // Edge counts between consecutive frame starts
    int cyc = 0, last_fs = 0, mc = 0, sc = 0, lc = 0;
    int last_per = 0, last_mc = 0, last_sc = 0, last_lc = 0;
    bit p_m = 0, p_s = 0, p_l = 0;
    always @(negedge clk) begin : periods
        cyc++;
        if (MCLK && !p_m) mc++;
        if (SCLK && !p_s) sc++;
        if (LRCLK && !p_l) lc++;
        if (frm_strt) begin
            last_per = cyc - last_fs; last_mc = mc; last_sc = sc; last_lc = lc;
            mc = 0; sc = 0; lc = 0; last_fs = cyc;
        end
        p_m = MCLK; p_s = SCLK; p_l = LRCLK;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        bus.lft_in = l; bus.rht_in = r; bus.in_vld = 1'b1;
        while (!bus.in_rdy && n < 3000) begin tick(); n++; end
        if (n >= 3000) expire("push");
        tick();
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_fs(input string name);
        int n = 0;
        do begin tick(); n++; end while (!frm_strt && n < 2100);
        if (!frm_strt) expire(name);
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx.size()) ? rx[i] : 32'hDEAD_BEEF;
    endfunction

    logic [31:0] pairs [8] = '{32'h0001_FFFF, 32'h7FFF_8000, 32'h1357_2468, 32'hFFFF_0000,
                               32'h8000_7FFF, 32'h0F0F_F0F0, 32'hC3C3_3C3C, 32'h0000_0001};

    initial begin
        rst = 1'b1; en = 1'b0; clr_undr = 1'b0;
        bus.lft_in = '0; bus.rht_in = '0; bus.in_vld = 1'b0;
        tick(3);
        chk("reset_pins", 32'({MCLK, SCLK, LRCLK, SDin, frm_strt, underrun, bus.in_rdy}), 32'h01);
        rst = 1'b0;
        tick(2);
        chk("idle_clocks", 32'({MCLK, SCLK, LRCLK, SDin}), 32'h0);

        // First pair accepted while idle, then start
        push(16'h8001, 16'h7FFE);
        chk("rdy_after_accept", 32'(bus.in_rdy), 32'h0);
        en = 1'b1;
        tick();
        chk("start_fs_rdy_undr", 32'({frm_strt, bus.in_rdy, underrun}), 32'h6);

        // Back-to-back pairs, one per frame
        for (int i = 0; i < 8; i++) push(pairs[i][31:16], pairs[i][15:0]);
        chk("no_underrun", 32'(underrun), 32'h0);
        chk("frame_period", 32'(last_per), 32'd1024);
        chk("mclk_per_frame", 32'(last_mc), 32'd256);
        chk("sclk_per_frame", 32'(last_sc), 32'd64);
        chk("lrclk_per_frame", 32'(last_lc), 32'd1);

        // Last pair, then starve
        push(16'h1234, 16'h5678);
        wait_fs("fs_1234");
        chk("undr_before_starve", 32'(underrun), 32'h0);
        wait_fs("fs_starve");
        chk("undr_starve", 32'(underrun), 32'h1);
        tick(500);
        clr_undr = 1'b1;
        tick();
        clr_undr = 1'b0;
        chk("undr_cleared", 32'(underrun), 32'h0);

        // Pair offered on the wrap cycle with the holding register empty; clear in the same cycle loses
        tick(522);
        bus.lft_in = 16'hA5A5; bus.rht_in = 16'h5A5A; bus.in_vld = 1'b1;
        clr_undr = 1'b1;
        tick();
        bus.in_vld = 1'b0; clr_undr = 1'b0;
        chk("wrap_accept", 32'({frm_strt, underrun, bus.in_rdy}), 32'h6);
        wait_fs("fs_a5a5");
        chk("rdy_after_load", 32'(bus.in_rdy), 32'h1);

        // Drop en mid-frame; frame completes then clocks stop
        tick(300);
        en = 1'b0;
        tick(723);
        chk("still_running", 32'(LRCLK), 32'h1);
        tick();
        chk("stopped", 32'({MCLK, SCLK, LRCLK, SDin, frm_strt}), 32'h0);
        tick(20);
        chk("stopped_hold", 32'({MCLK, SCLK, LRCLK, SDin}), 32'h0);
        en = 1'b1;
        tick();
        chk("restart_fs", 32'(frm_strt), 32'h1);
        chk("rx_count", 32'(rx.size()), 32'd13);

        // Reset mid-frame
        push(16'h0F0F, 16'hF0F0);
        tick(599);
        rst = 1'b1;
        tick();
        chk("midframe_reset", 32'({MCLK, SCLK, LRCLK, SDin, frm_strt, underrun, bus.in_rdy}), 32'h01);
        rst = 1'b0;
        tick(2);
        chk("after_reset_idle", 32'({MCLK, SCLK, LRCLK, SDin, frm_strt, bus.in_rdy}), 32'h01);

        // Decoded frames: literal expectations, then the full list against the model
        chk("rx0", rx_at(0), 32'h8001_7FFE);
        for (int i = 0; i < 8; i++) chk("rx_pair", rx_at(i + 1), pairs[i]);
        chk("rx9", rx_at(9), 32'h1234_5678);
        chk("rx10_underrun", rx_at(10), UNDR_PAIR);
        chk("rx11_wrap", rx_at(11), UNDR_PAIR);
        chk("rx12_late_pair", rx_at(12), 32'hA5A5_5A5A);
        chk("rx_total", 32'(rx.size()), 32'd13);
        for (int i = 0; i < rx.size() && i < m_sent.size(); i++) chk("rx_vs_model", rx[i], m_sent[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
